// File: rtl/hud_controller.sv
// Arcade HUD state: score, lives, post-hit blink window and game-over flag,
// all advanced on a free-running display refresh divider.
module hud_controller #(
  parameter int REFRESH_DIV = 50000,
  parameter int HIT_TICKS   = 256,
  parameter int BLINK_TICKS = 32
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       new_game,
  input  logic       alien_hit,
  input  logic       ufo_hit,
  input  logic       player_hit,
  output logic       disp_tick,
  output logic [6:0] score,
  output logic [1:0] lives,
  output logic       lives_visible,
  output logic       game_over
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = $clog2(HIT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hit_q, hit_d, hit_m1;
  logic [BW-1:0] blink_q, blink_d, blink_m1;
  logic [6:0]    score_d, score_sat;
  logic [7:0]    score_sum;
  logic [1:0]    lives_d;
  logic          vis_d;

  // Divider runs in every state; the tick is registered, so the FSM sees it
  // on the cycle following the wrap.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      div_cnt   <= '0;
      disp_tick <= 1'b0;
    end else if (div_cnt == DW'(REFRESH_DIV - 1)) begin
      div_cnt   <= '0;
      disp_tick <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      disp_tick <= 1'b0;
    end
  end

  assign score_sum = {1'b0, score} + {7'b0, alien_hit} + (ufo_hit ? 8'd5 : 8'd0);
  assign score_sat = (score_sum > 8'd99) ? 7'd99 : score_sum[6:0];
  assign hit_m1    = hit_q - 1'b1;
  assign blink_m1  = blink_q - 1'b1;

  always_comb begin
    state_d = state_q;
    score_d = score;
    lives_d = lives;
    vis_d   = lives_visible;
    hit_d   = hit_q;
    blink_d = blink_q;
    if (new_game) begin
      state_d = PLAY;
      score_d = '0;
      lives_d = 2'd3;
      vis_d   = 1'b1;
      hit_d   = '0;
      blink_d = '0;
    end else begin
      case (state_q)
        PLAY: begin
          score_d = score_sat;
          if (player_hit) begin
            if (lives >= 2'd2) begin
              lives_d = lives - 1'b1;
              state_d = HIT;
              hit_d   = HW'(HIT_TICKS);
              blink_d = BW'(BLINK_TICKS);
              vis_d   = 1'b0;
            end else begin
              lives_d = '0;
              state_d = OVER;
              vis_d   = 1'b1;
            end
          end
        end
        HIT: begin
          score_d = score_sat;
          if (disp_tick) begin
            hit_d = hit_m1;
            // End of window wins over a coincident blink toggle.
            if (hit_m1 == '0) begin
              state_d = PLAY;
              vis_d   = 1'b1;
            end else if (blink_m1 == '0) begin
              vis_d   = ~lives_visible;
              blink_d = BW'(BLINK_TICKS);
            end else begin
              blink_d = blink_m1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      score         <= '0;
      lives         <= 2'd3;
      lives_visible <= 1'b1;
      game_over     <= 1'b0;
      hit_q         <= '0;
      blink_q       <= '0;
    end else begin
      state_q       <= state_d;
      score         <= score_d;
      lives         <= lives_d;
      lives_visible <= vis_d;
      game_over     <= (state_d == OVER);
      hit_q         <= hit_d;
      blink_q       <= blink_d;
    end
  end

endmodule

// File: tb/tb_hud_controller.sv
// Randomized and directed bench for hud_controller against a time-based
// reference model (ticks elapsed since the hit, not counter registers).
module tb_hud_controller;

  localparam int DIV = 4, HT = 8, BT = 2;

  logic       clk = 1'b0, arst_n = 1'b0;
  logic       new_game = 0, alien_hit = 0, ufo_hit = 0, player_hit = 0;
  logic       disp_tick, lives_visible, game_over;
  logic [6:0] score;
  logic [1:0] lives;

  int errors = 0, checks = 0;

  // model: mode 0 idle, 1 playing, 2 invulnerable, 3 game over
  int m_mode, m_score, m_lives, m_vis, m_elapsed, m_cyc, m_tick;

  hud_controller #(.REFRESH_DIV(DIV), .HIT_TICKS(HT), .BLINK_TICKS(BT)) dut (
    .clk(clk), .arst_n(arst_n), .new_game(new_game), .alien_hit(alien_hit),
    .ufo_hit(ufo_hit), .player_hit(player_hit), .disp_tick(disp_tick),
    .score(score), .lives(lives), .lives_visible(lives_visible), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] m_out();
    return {m_tick[0], 7'(m_score), 2'(m_lives), m_vis[0], (m_mode == 3)};
  endfunction

  function automatic logic [11:0] d_out();
    return {disp_tick, score, lives, lives_visible, game_over};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_score = 0; m_lives = 3; m_vis = 1; m_elapsed = 0;
    m_cyc = 0; m_tick = 0;
  endtask

  task automatic model_edge(input int ng, ah, uh, ph);
    int tick_seen;
    tick_seen = m_tick;
    if (ng != 0) begin
      m_mode = 1; m_score = 0; m_lives = 3; m_vis = 1; m_elapsed = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_score = m_score + ah + 5 * uh;
      if (m_score > 99) m_score = 99;
      if (m_mode == 1 && ph != 0) begin
        if (m_lives >= 2) begin
          m_lives--; m_mode = 2; m_elapsed = 0; m_vis = 0;
        end else begin
          m_lives = 0; m_mode = 3; m_vis = 1;
        end
      end else if (m_mode == 2 && tick_seen != 0) begin
        m_elapsed++;
        if (m_elapsed == HT) begin
          m_mode = 1; m_vis = 1;
        end else m_vis = (m_elapsed / BT) % 2;
      end
    end
    m_cyc++;
    m_tick = (m_cyc % DIV == 0) ? 1 : 0;
  endtask

  // Called at the negedge; leaves us at the next negedge with pulses cleared.
  task automatic step(input logic ng, ah, uh, ph);
    new_game = ng; alien_hit = ah; ufo_hit = uh; player_hit = ph;
    model_edge(int'(ng), int'(ah), int'(uh), int'(ph));
    @(posedge clk);
    @(negedge clk);
    new_game = 0; alien_hit = 0; ufo_hit = 0; player_hit = 0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (d_out() !== {1'b0, 7'd0, 2'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", d_out(), {1'b0, 7'd0, 2'd3, 1'b1, 1'b0});
    end
    // inputs while held in reset change nothing
    arst_n = 1'b0;
    new_game = 1; alien_hit = 1; ufo_hit = 1;
    repeat (3) @(negedge clk);
    new_game = 0; alien_hit = 0; ufo_hit = 0;
    checks++;
    if (d_out() !== {1'b0, 7'd0, 2'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", d_out(), {1'b0, 7'd0, 2'd3, 1'b1, 1'b0});
    end
    arst_n = 1'b1;
  endtask

  task automatic test_divider();
    int pulses = 0, prev = 0, adjacent = 0;
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 0, 0);
      if (disp_tick === 1'b1) pulses++;
      if (disp_tick === 1'b1 && prev == 1) adjacent++;
      prev = (disp_tick === 1'b1) ? 1 : 0;
      checks++;
      if (disp_tick !== ((k % DIV) == 0)) begin
        errors++; $display("FAIL div_phase cyc=%0d got=%b exp=%b", k, disp_tick, (k % DIV) == 0);
      end
    end
    checks++;
    if (pulses != 4 || adjacent != 0) begin
      errors++; $display("FAIL div_count got=%0d/%0d exp=4/0", pulses, adjacent);
    end
  endtask

  task automatic test_idle();
    step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    checks++;
    if ({score, lives, game_over} !== {7'd0, 2'd3, 1'b0}) begin
      errors++; $display("FAIL idle_ignore got=%0d/%0d exp=0/3", score, lives);
    end
    step(1, 0, 0, 1);
    step(0, 1, 0, 0);
    checks++;
    if ({score, lives} !== {7'd1, 2'd3}) begin
      errors++; $display("FAIL idle_newgame_hit got=%0d/%0d exp=1/3", score, lives);
    end
  endtask

  task automatic test_score();
    step(1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    checks++;
    if (score !== 7'd9) begin
      errors++; $display("FAIL score_nine got=%0d exp=9", score);
    end
    repeat (17) step(0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0);
    checks++;
    if (score !== 7'd97) begin
      errors++; $display("FAIL score_97 got=%0d exp=97", score);
    end
    step(0, 0, 1, 0);
    checks++;
    if (score !== 7'd99) begin
      errors++; $display("FAIL score_sat got=%0d exp=99", score);
    end
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    checks++;
    if (score !== 7'd99) begin
      errors++; $display("FAIL score_hold got=%0d exp=99", score);
    end
  endtask

  task automatic test_hit();
    int toggles = 0;
    logic prev_vis;
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    checks++;
    if ({lives, lives_visible} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL hit_enter got=%0d/%b exp=2/0", lives, lives_visible);
    end
    step(0, 0, 0, 1);
    checks++;
    if (lives !== 2'd2) begin
      errors++; $display("FAIL hit_ignore got=%0d exp=2", lives);
    end
    prev_vis = lives_visible;
    for (int k = 0; k < HT * DIV + 4; k++) begin
      step(0, 0, 0, 0);
      if (lives_visible !== prev_vis) toggles++;
      prev_vis = lives_visible;
      checks++;
      if (d_out() !== m_out()) begin
        errors++; $display("FAIL hit_window k=%0d got=%h exp=%h", k, d_out(), m_out());
      end
    end
    checks++;
    if (toggles != 3 || lives_visible !== 1'b1) begin
      errors++; $display("FAIL hit_blink got=%0d/%b exp=3/1", toggles, lives_visible);
    end
    step(0, 0, 0, 1);
    checks++;
    if (lives !== 2'd1) begin
      errors++; $display("FAIL hit_back_to_play got=%0d exp=1", lives);
    end
  endtask

  task automatic test_over();
    step(1, 0, 0, 0);
    for (int h = 0; h < 3; h++) begin
      step(0, 0, 0, 1);
      checks++;
      if (lives !== 2'(2 - h)) begin
        errors++; $display("FAIL over_lives h=%0d got=%0d exp=%0d", h, lives, 2 - h);
      end
      if (h < 2) repeat (HT * DIV + 4) step(0, 0, 0, 0);
    end
    checks++;
    if ({game_over, lives_visible} !== 2'b11) begin
      errors++; $display("FAIL over_flag got=%b exp=11", {game_over, lives_visible});
    end
    step(0, 1, 1, 1);
    checks++;
    if ({score, lives, game_over} !== {7'd0, 2'd0, 1'b1}) begin
      errors++; $display("FAIL over_frozen got=%0d/%0d/%b exp=0/0/1", score, lives, game_over);
    end
    step(1, 1, 0, 0);
    checks++;
    if ({score, lives, game_over} !== {7'd0, 2'd3, 1'b0}) begin
      errors++; $display("FAIL over_restart got=%0d/%0d/%b exp=0/3/0", score, lives, game_over);
    end
  endtask

  task automatic test_last_life_scored();
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (HT * DIV + 4) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (HT * DIV + 4) step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    checks++;
    if ({score, lives, game_over} !== {7'd6, 2'd0, 1'b1}) begin
      errors++; $display("FAIL last_life_score got=%0d/%0d/%b exp=6/0/1", score, lives, game_over);
    end
  endtask

  task automatic test_random();
    logic ng, ah, uh, ph;
    for (int k = 0; k < 1500; k++) begin
      ng = ($urandom_range(0, 199) == 0);
      ah = ($urandom_range(0, 2) == 0);
      uh = ($urandom_range(0, 7) == 0);
      ph = ($urandom_range(0, 39) == 0);
      step(ng, ah, uh, ph);
      checks++;
      if (d_out() !== m_out()) begin
        errors++; $display("FAIL random k=%0d got=%h exp=%h", k, d_out(), m_out());
      end
    end
  endtask

  task automatic test_reset_mid_hit();
    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 1, 0);
    repeat (2) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    checks++;
    if ({score, lives, lives_visible} !== {7'd42, 2'd2, 1'b0}) begin
      errors++; $display("FAIL pre_abort got=%0d/%0d/%b exp=42/2/0", score, lives, lives_visible);
    end
    #2 arst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (d_out() !== {1'b0, 7'd0, 2'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL async_abort got=%h exp=%h", d_out(), {1'b0, 7'd0, 2'd3, 1'b1, 1'b0});
    end
    @(negedge clk);
    arst_n = 1'b1;
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    checks++;
    if (d_out() !== m_out() || score !== 7'd0) begin
      errors++; $display("FAIL abort_idle got=%h exp=%h", d_out(), m_out());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_divider();
    test_idle();
    test_score();
    test_hit();
    test_over();
    test_last_life_scored();
    test_random();
    test_reset_mid_hit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hud_controller.md
HUD_CONTROLLER -- requirements
Module: hud_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles per display refresh tick.
REQ-002 Parameter HIT_TICKS, default 256: refresh ticks the post-hit (invulnerable) window lasts.
REQ-003 Parameter BLINK_TICKS, default 32: refresh ticks per lives_visible toggle during the hit window.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 arst_n  input  1  reset, asynchronous and active-low; one clock, no other reset.
REQ-006 new_game  input  1  one-cycle pulse, start/restart game.
REQ-007 alien_hit  input  1  one-cycle pulse, +1 point.
REQ-008 ufo_hit  input  1  one-cycle pulse, +5 points.
REQ-009 player_hit  input  1  one-cycle pulse, player struck.
REQ-010 disp_tick  output  1  one-cycle refresh strobe for the seven-segment driver enable.
REQ-011 score  output  7  current score, 0-99, binary.
REQ-012 lives  output  2  remaining lives, 0-3.
REQ-013 lives_visible  output  1  1 = lives digit shown, 0 = blanked (blink).
REQ-014 game_over  output  1  high while in OVER.

Function
REQ-015 Divider counts 0..REFRESH_DIV-1 continuously in every state; disp_tick high exactly one cycle when counter wraps to 0 (period REFRESH_DIV cycles).
REQ-016 FSM states IDLE, PLAY, HIT, OVER; all outputs registered, updated one cycle after the causing input edge.
REQ-017 new_game in any state -> PLAY, score=0, lives=3, lives_visible=1, game_over=0, hit/blink counters cleared; overrides all same-cycle events.
REQ-018 IDLE: only new_game acts; alien_hit, ufo_hit, player_hit ignored.
REQ-019 PLAY, player_hit with lives>=2 -> lives-1, HIT, hit counter=HIT_TICKS, blink counter=BLINK_TICKS, lives_visible=0.
REQ-020 PLAY, player_hit with lives==1 -> lives=0, OVER, game_over=1, lives_visible=1.
REQ-021 HIT: player_hit ignored; on each disp_tick hit counter decrements; counter reaching 0 -> PLAY, lives_visible=1.
REQ-022 HIT: on each disp_tick blink counter decrements; on reaching 0 lives_visible toggles and blink counter reloads BLINK_TICKS.
REQ-023 Scoring active in PLAY and HIT only: score += alien_hit*1 + ufo_hit*5; both same cycle adds 6.
REQ-024 Score saturates at 99 (e.g. 97 + ufo_hit = 99); never wraps; 8-bit internal sum before clamp.
REQ-025 Same cycle in PLAY: player_hit and score pulses both take effect (score added, life removed), including the final-life case (score added, then OVER).
REQ-026 OVER: score and lives frozen; all inputs except new_game ignored.

Reset
REQ-027 arst_n low asynchronously forces: IDLE, score=0, lives=3, lives_visible=1, game_over=0, disp_tick=0, divider and hit/blink counters 0.
REQ-028 Reset asserted mid-HIT or mid-OVER fully aborts; after release block stays in IDLE until new_game.
REQ-029 No state change while arst_n low regardless of inputs.

Verification
REQ-030 REFRESH_DIV=4: after reset release, disp_tick pulses every 4th cycle, width 1 cycle, uninterrupted across state changes.
REQ-031 new_game, 3x alien_hit, 1 cycle with alien_hit+ufo_hit -> score=9; drive to 97, ufo_hit -> 99; further alien_hit -> stays 99.
REQ-032 HIT_TICKS=8, BLINK_TICKS=2, REFRESH_DIV=4: player_hit in PLAY -> lives 3->2, lives_visible toggles every 2 ticks, second player_hit during window ignored, PLAY after 8 ticks with lives_visible=1.
REQ-033 Three spaced player_hits -> lives 3,2,1,0; last gives game_over=1; alien_hit in OVER leaves score unchanged; new_game -> score 0, lives 3, game_over 0.
REQ-034 IDLE: alien_hit/player_hit ignored (score 0, lives 3); new_game+player_hit same cycle -> PLAY, lives 3.
REQ-035 arst_n pulsed low mid-HIT with score 42 -> immediately score 0, lives 3, lives_visible 1, IDLE.
